data_sram_resp: RTL
===================

# data_sram_resp

Responder end of the data SRAM interface driven by the execute stage: a synchronous, single-port, word-organised data memory with per-byte write enables and fixed one-cycle read latency. Load data is returned to the memory stage on the cycle after the request. After every reset the block runs a self-clear sequence, zeroing the whole array. It flags accesses outside its address window and emits a one-cycle write trace for the verification environment.

## Interface
Parameters:
- ADDR_BITS, 10, word-address width; array holds 2^ADDR_BITS 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_sram_en  in  1  request valid this cycle.
- data_sram_wen  in  4  byte write enables; bit i writes wdata[8i+7:8i]; 4'h0 means read.
- data_sram_addr  in  32  byte address; bits [1:0] are ignored.
- data_sram_wdata  in  32  store data.
- data_sram_rdata  out  32  read data; valid the cycle after an accepted request.
- init_done  out  1  high once the self-clear has finished.
- addr_err  out  1  sticky; an out-of-window request occurred.
- err_addr  out  32  address of the first out-of-window request.
- trace_valid  out  1  one-cycle pulse; a write committed in the previous cycle.
- trace_addr  out  32  word-aligned byte address of the committed write.
- trace_wen  out  4  byte enables of the committed write.
- trace_wdata  out  32  write data as presented on the request.

## Operation
- FSM states: CLEAR and RUN.
  - reset forces CLEAR and sets clr_idx to 0.
  - In CLEAR, mem[clr_idx] is written with 0 each cycle and clr_idx increments.
  - When clr_idx == 2^ADDR_BITS-1 has been written, the FSM moves to RUN and init_done rises on the next edge.
  - RUN is left only by reset.
- Offset: off = data_sram_addr - BASE_ADDR (32-bit, modulo 2^32).
- Window: in_range = (off >> 2) < 2^ADDR_BITS. Word index = off[ADDR_BITS+1:2].
- Accepted request: data_sram_en && state==RUN.
  - Requests arriving in CLEAR are ignored completely. They do not write, do not set addr_err and do not emit a trace. rdata is driven to 0.
- Read (accepted, in range): rdata <= mem[idx] on the next edge.
  - Read-first: if wen != 0 on the same cycle, rdata returns the pre-write word.
- Write (accepted, in range, wen != 0): only the enabled bytes of mem[idx] are updated. The other bytes are unchanged.
- Out of range (accepted, !in_range):
  - No array access. rdata <= 0.
  - addr_err <= 1.
  - err_addr captures data_sram_addr only if addr_err was 0 before that edge (first error wins).
- Idle (en=0, or in CLEAR after the first cycle): rdata holds its last value.
  - The exception: every CLEAR cycle forces rdata to 0.
- Trace registers:
  - On the edge after an in-range committed write: trace_valid=1, trace_addr = {data_sram_addr[31:2],2'b00}, trace_wen = wen, trace_wdata = wdata.
  - trace_valid is 0 in every other cycle. The other trace fields hold their values.

## Timing
- Reset values (the cycle after reset is sampled high):
  - rdata = 0, init_done = 0, addr_err = 0, err_addr = 0.
  - trace_valid = 0, trace_addr = 0, trace_wen = 0, trace_wdata = 0.
- Clear duration: exactly 2^ADDR_BITS cycles after reset deasserts. init_done is high from the edge that completes the final clear write.
- Read latency: 1 cycle. A request in cycle N gives rdata in cycle N+1.
- Write latency: 1 cycle. A read of the same word in cycle N+1 returns the new data.
- Back-to-back requests: one per cycle, no stalls. There is no ready signal; the requester must wait for init_done.
- Reset mid-CLEAR or mid-RUN:
  - All outputs return to their reset values and clearing restarts at index 0.
  - addr_err and err_addr are cleared.
- Address wrap-around: an address below BASE_ADDR wraps to a large off and is therefore out of range.

## Test plan
- Reset, then count cycles with ADDR_BITS=4 -> init_done rises exactly 16 cycles after reset deasserts. Reads of every word then return 32'h0.
- Write 0x11223344 to 0x8 with wen=4'hF, then a write of 0xAABBCCDD with wen=4'b0101, then a read of 0x8 -> rdata = 0x11BB33DD one cycle after the read. trace pulses carry (0x8, F, 0x11223344) and then (0x8, 5, 0xAABBCCDD).
- Same-cycle read+write to 0x4 (old value 0x0, wdata 0xDEADBEEF) -> rdata = 0x0. The next read of 0x4 returns 0xDEADBEEF.
- ADDR_BITS=4, BASE_ADDR=0x1000:
  - Read 0x1040 -> rdata 0, addr_err=1, err_addr=0x1040.
  - A later access to 0x0FFC -> err_addr stays 0x1040, no trace pulse.
  - A write to 0x103C succeeds.
- Assert data_sram_en with wen=F during CLEAR -> the word stays 0 after init, no trace pulse, addr_err stays 0.
- Reset asserted 5 cycles into RUN with addr_err=1 and memory written -> addr_err=0, init_done=0, and after 16 cycles all words read 0.

Source files
------------

// File: rtl/data_sram_resp.sv
// Data SRAM responder: single-port word memory with byte enables, self-clear after reset, window check and write trace.
// Latency: one cycle for read data and for write commit; the self-clear takes 2^ADDR_BITS cycles after reset.
// Backpressure: none. One request per cycle is accepted in RUN; requests arriving in CLEAR are ignored.
module data_sram_resp #(
  parameter int          ADDR_BITS = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic        addr_err,
  output logic [31:0] err_addr,
  output logic        trace_valid,
  output logic [31:0] trace_addr,
  output logic [3:0]  trace_wen,
  output logic [31:0] trace_wdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {CLEAR, RUN} state_t;

  logic [31:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clr_idx_q, clr_idx_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   init_done_q, init_done_d;
  logic                   addr_err_q, addr_err_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic                   trace_valid_q, trace_valid_d;
  logic [31:0]            trace_addr_q, trace_addr_d;
  logic [3:0]             trace_wen_q, trace_wen_d;
  logic [31:0]            trace_wdata_q, trace_wdata_d;

  // Word offset from the window base; BASE_ADDR is word aligned so the byte bits drop out.
  logic [29:0]            off_w;
  logic                   in_range;
  logic [ADDR_BITS-1:0]   idx;
  logic                   accept;
  logic                   do_wr;

  // Decode the request against the address window.
  always_comb begin
    off_w    = data_sram_addr[31:2] - BASE_ADDR[31:2];
    in_range = (off_w[29:ADDR_BITS] == '0);
    idx      = off_w[ADDR_BITS-1:0];
    accept   = data_sram_en && (state_q == RUN);
    do_wr    = accept && in_range && (data_sram_wen != 4'h0);
  end

  // Next-state logic for the FSM, read data, error capture and trace.
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    rdata_d       = rdata_q;
    init_done_d   = init_done_q;
    addr_err_d    = addr_err_q;
    err_addr_d    = err_addr_q;
    trace_valid_d = do_wr;
    trace_addr_d  = trace_addr_q;
    trace_wen_d   = trace_wen_q;
    trace_wdata_d = trace_wdata_q;

    if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      rdata_d   = 32'h0;
      if (clr_idx_q == '1) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end else if (accept) begin
      if (in_range) begin
        // Read-first: a same-cycle write returns the word as it was before.
        rdata_d = mem[idx];
      end else begin
        rdata_d    = 32'h0;
        addr_err_d = 1'b1;
        if (!addr_err_q) err_addr_d = data_sram_addr;
      end
    end

    if (do_wr) begin
      trace_addr_d  = {data_sram_addr[31:2], 2'b00};
      trace_wen_d   = data_sram_wen;
      trace_wdata_d = data_sram_wdata;
    end
  end

  // FSM and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR;
      clr_idx_q     <= '0;
      rdata_q       <= 32'h0;
      init_done_q   <= 1'b0;
      addr_err_q    <= 1'b0;
      err_addr_q    <= 32'h0;
      trace_valid_q <= 1'b0;
      trace_addr_q  <= 32'h0;
      trace_wen_q   <= 4'h0;
      trace_wdata_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      clr_idx_q     <= clr_idx_d;
      rdata_q       <= rdata_d;
      init_done_q   <= init_done_d;
      addr_err_q    <= addr_err_d;
      err_addr_q    <= err_addr_d;
      trace_valid_q <= trace_valid_d;
      trace_addr_q  <= trace_addr_d;
      trace_wen_q   <= trace_wen_d;
      trace_wdata_q <= trace_wdata_d;
    end
  end

  // Array writes: zero-fill while clearing, byte-masked stores while running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[clr_idx_q] <= 32'h0;
      end else if (do_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (data_sram_wen[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign init_done       = init_done_q;
  assign addr_err        = addr_err_q;
  assign err_addr        = err_addr_q;
  assign trace_valid     = trace_valid_q;
  assign trace_addr      = trace_addr_q;
  assign trace_wen       = trace_wen_q;
  assign trace_wdata     = trace_wdata_q;

endmodule
